// File: rtl/vr_rr_mux_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : vr_rr_mux_pipe_if
//  Description : Valid/ready bundle for vr_rr_mux_pipe. It carries the N
//                producer channels (A/A_VALID/A_READY) and the single
//                consumer channel (Y/Y_VALID/Y_CH/Y_READY).
//                slave  : mux side (accepts A, drives Y)
//                master : environment side (drives A, accepts Y)
//  Parameters  : S (select width, N = 2**S), M (data width per channel)
//  Revision    : 1.0 - initial release
// ============================================================================
interface vr_rr_mux_pipe_if #(
  parameter int S = 4,
  parameter int M = 8
);
  localparam int N = 1 << S;

  logic [N*M-1:0] A;
  logic [N-1:0]   A_VALID;
  logic [N-1:0]   A_READY;
  logic [M-1:0]   Y;
  logic           Y_VALID;
  logic [S-1:0]   Y_CH;
  logic           Y_READY;

  modport slave (
    input  A, A_VALID, Y_READY,
    output A_READY, Y, Y_VALID, Y_CH
  );

  modport master (
    output A, A_VALID, Y_READY,
    input  A_READY, Y, Y_VALID, Y_CH
  );
endinterface
`default_nettype wire

// File: rtl/vr_rr_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : vr_rr_mux_pipe
//  Description : Registered 2**S-channel, M-bit multiplexer with valid/ready
//                handshakes. Direct (SEL) or round-robin selection.
//  Ports       : CLK, RST (sync, active-high)
//                EN    - allow new grants
//                MODE  - 0 direct, 1 round-robin
//                SEL   - channel used in direct mode
//                LOCK  - (only with VR_MUX_LOCK_EN) pin round-robin to Y_CH
//                bus   - vr_rr_mux_pipe_if.slave: A/A_VALID/A_READY inputs,
//                        Y/Y_VALID/Y_CH/Y_READY output
//  Options     : `define VR_MUX_LOCK_EN adds the LOCK burst-lock input.
//  Revision    : 1.0 - initial release
// ============================================================================
module vr_rr_mux_pipe #(
  parameter int S = 4,
  parameter int M = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         MODE,
  input  logic [S-1:0] SEL,
`ifdef VR_MUX_LOCK_EN
  input  logic         LOCK,
`endif
  vr_rr_mux_pipe_if.slave bus
);
  localparam int N = 1 << S;

  logic [M-1:0] y_q,       y_d;
  logic         y_valid_q, y_valid_d;
  logic [S-1:0] y_ch_q,    y_ch_d;
  logic [S-1:0] ptr_q,     ptr_d;

  logic         load;
  logic         lock_active;
  logic         rr_found;
  logic [S-1:0] rr_idx;
  logic [S-1:0] probe;
  logic [S-1:0] cand;
  logic         cand_ok;
  logic         grant;

  // The register can take a new word when it is empty or being drained.
  // Y_READY only matters here while Y_VALID=1.
  assign load = EN & (~y_valid_q | bus.Y_READY);

`ifdef VR_MUX_LOCK_EN
  // seen_q marks that Y_CH names a real channel; before the first load
  // after reset the lock has nothing to pin to.
  logic seen_q, seen_d;
  assign lock_active = MODE & LOCK & seen_q;
`else
  assign lock_active = 1'b0;
`endif

  // Round-robin search starting one past the last winner; the last probe
  // (offset N) wraps back onto ptr_q itself, so a lone valid channel
  // wins every cycle.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    probe    = ptr_q;
    for (int i = 1; i <= N; i++) begin
      probe = ptr_q + S'(i);
      if (!rr_found && bus.A_VALID[probe]) begin
        rr_found = 1'b1;
        rr_idx   = probe;
      end
    end
  end

  always_comb begin
    cand    = SEL;
    cand_ok = bus.A_VALID[SEL];
    if (MODE) begin
      if (lock_active) begin
        // Locked: only the current burst owner may continue.
        cand    = y_ch_q;
        cand_ok = bus.A_VALID[y_ch_q];
      end else begin
        cand    = rr_idx;
        cand_ok = rr_found;
      end
    end
  end

  assign grant       = load & cand_ok & ~RST;
  assign bus.A_READY = grant ? (N'(1) << cand) : '0;

  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_ch_d    = y_ch_q;
    ptr_d     = ptr_q;
`ifdef VR_MUX_LOCK_EN
    seen_d    = seen_q;
`endif
    if (grant) begin
      y_d       = bus.A[int'(cand)*M +: M];
      y_valid_d = 1'b1;
      y_ch_d    = cand;
      if (MODE) begin
        ptr_d = cand;
      end
`ifdef VR_MUX_LOCK_EN
      seen_d    = 1'b1;
`endif
    end else if (y_valid_q && bus.Y_READY) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_ch_q    <= '0;
      ptr_q     <= S'(N - 1);
`ifdef VR_MUX_LOCK_EN
      seen_q    <= 1'b0;
`endif
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_ch_q    <= y_ch_d;
      ptr_q     <= ptr_d;
`ifdef VR_MUX_LOCK_EN
      seen_q    <= seen_d;
`endif
    end
  end

  assign bus.Y       = y_q;
  assign bus.Y_VALID = y_valid_q;
  assign bus.Y_CH    = y_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_vr_rr_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vr_rr_mux_pipe
//  Description : Self-checking bench for vr_rr_mux_pipe (S=2, M=8) with a
//                behavioural reference model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vr_rr_mux_pipe;
  localparam int S = 2;
  localparam int M = 8;
  localparam int N = 1 << S;

  logic         clk;
  logic         rst;
  logic         en;
  logic         mode;
  logic [S-1:0] sel;
  logic         lock;

  vr_rr_mux_pipe_if #(.S(S), .M(M)) bus ();

  vr_rr_mux_pipe #(.S(S), .M(M)) u_dut (
    .CLK  (clk),
    .RST  (rst),
    .EN   (en),
    .MODE (mode),
    .SEL  (sel),
`ifdef VR_MUX_LOCK_EN
    .LOCK (lock),
`endif
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [M-1:0] m_y;
  logic         m_valid;
  int           m_ch;
  int           m_ptr;
  logic         m_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_y     = '0;
    m_valid = 1'b0;
    m_ch    = 0;
    m_ptr   = N - 1;
    m_seen  = 1'b0;
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle against the model,
  // then advance the model across the edge. Entered and left at posedge+1.
  task automatic step(input logic en_i, input logic mode_i, input logic [S-1:0] sel_i,
                      input logic [N-1:0] av_i, input logic [N*M-1:0] a_i,
                      input logic yr_i, input logic lock_i, input logic rst_i);
    logic         ld;
    logic         lk;
    int           win;
    logic [N-1:0] exp_rdy;
    en          = en_i;
    mode        = mode_i;
    sel         = sel_i;
    bus.A_VALID = av_i;
    bus.A       = a_i;
    bus.Y_READY = yr_i;
    lock        = lock_i;
    rst         = rst_i;
`ifdef VR_MUX_LOCK_EN
    lk = mode_i && lock_i && m_seen;
`else
    lk = 1'b0;
`endif
    ld  = en_i && (!m_valid || yr_i) && !rst_i;
    win = -1;
    if (ld) begin
      if (!mode_i) begin
        if (av_i[sel_i]) win = int'(sel_i);
      end else if (lk) begin
        if (av_i[m_ch]) win = m_ch;
      end else begin
        for (int d = 1; d <= N; d++) begin
          if (win < 0 && av_i[(m_ptr + d) % N]) win = (m_ptr + d) % N;
        end
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    @(negedge clk);
    chk("a_ready", 64'(bus.A_READY), 64'(exp_rdy));
    chk("y",       64'(bus.Y),       64'(m_y));
    chk("y_valid", 64'(bus.Y_VALID), 64'(m_valid));
    chk("y_ch",    64'(bus.Y_CH),    64'(m_ch));
    @(posedge clk);
    #1;
    if (rst_i) begin
      model_reset();
    end else if (win >= 0) begin
      m_y     = a_i[win*M +: M];
      m_valid = 1'b1;
      m_ch    = win;
      m_seen  = 1'b1;
      if (mode_i) m_ptr = win;
    end else if (m_valid && yr_i) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [N*M-1:0] data;
  logic [N-1:0]   all_v;
  logic [N-1:0]   av;

  initial begin
    rst         = 1'b1;
    en          = 1'b0;
    mode        = 1'b0;
    sel         = '0;
    lock        = 1'b0;
    bus.A       = '0;
    bus.A_VALID = '0;
    bus.Y_READY = 1'b0;
    all_v       = '1;
    // Bring the DUT out of the unknown power-up state before checking.
    @(posedge clk);
    #1;
    model_reset();
    do_reset();

    // Direct mode: SEL=2 takes channel 2's word.
    data = 32'h11A5_3344;
    av   = 4'b0100;
    step(1'b1, 1'b0, 2'd2, av, data, 1'b1, 1'b0, 1'b0);
    chk("t1_y", 64'(bus.Y), 64'h A5);
    chk("t1_ch", 64'(bus.Y_CH), 64'd2);
    chk("t1_valid", 64'(bus.Y_VALID), 64'd1);

    // Round-robin with all channels valid: 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      data = $urandom;
      step(1'b1, 1'b1, '0, all_v, data, 1'b1, 1'b0, 1'b0);
      chk("t2_seq", 64'(bus.Y_CH), 64'(i % N));
    end

    // Back-pressure: channel 1 frozen, then 3 loads as 1 drains.
    do_reset();
    av   = 4'b1010;
    data = 32'hD3C2_B1A0;
    step(1'b1, 1'b1, '0, av, data, 1'b0, 1'b0, 1'b0);
    chk("t3_ch1", 64'(bus.Y_CH), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '0, av, data, 1'b0, 1'b0, 1'b0);
    chk("t3_frozen", 64'(bus.Y), 64'h B1);
    step(1'b1, 1'b1, '0, av, data, 1'b1, 1'b0, 1'b0);
    chk("t3_ch3", 64'(bus.Y_CH), 64'd3);
    chk("t3_y3", 64'(bus.Y), 64'h D3);

    // EN=0 drains the held word, no new load.
    step(1'b0, 1'b1, '0, all_v, data, 1'b1, 1'b0, 1'b0);
    chk("t4_drained", 64'(bus.Y_VALID), 64'd0);
    step(1'b0, 1'b1, '0, all_v, data, 1'b1, 1'b0, 1'b0);

    // Reset with a held word, then first grant goes to channel 0.
    step(1'b1, 1'b1, '0, all_v, data, 1'b0, 1'b0, 1'b0);
    do_reset();
    chk("t5_y", 64'(bus.Y), 64'd0);
    chk("t5_valid", 64'(bus.Y_VALID), 64'd0);
    step(1'b1, 1'b1, '0, all_v, data, 1'b1, 1'b0, 1'b0);
    chk("t5_first", 64'(bus.Y_CH), 64'd0);

`ifdef VR_MUX_LOCK_EN
    // Burst lock on channel 2, release hands over to channel 3.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '0, all_v, data, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, '0, all_v, data, 1'b1, 1'b1, 1'b0);
      chk("t6_locked", 64'(bus.Y_CH), 64'd2);
    end
    step(1'b1, 1'b1, '0, all_v, data, 1'b1, 1'b0, 1'b0);
    chk("t6_release", 64'(bus.Y_CH), 64'd3);
`endif

    // Randomized traffic against the model.
    begin
      logic r_mode;
      r_mode = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 31) == 0) r_mode = ~r_mode;
        step($urandom_range(0, 7) != 0, r_mode, S'($urandom),
             N'($urandom), $urandom, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
